// File: rtl/rom_load_ctrl_if.sv
// rom_load_ctrl_if: groups the host download port (ioctl_*), the region
// write port (rom_wr_*) and the core status flags of rom_load_ctrl.
// master = download host / ROM regions side, slave = rom_load_ctrl.
// Build option: CCLIMB_ROM_CHECKSUM_EN adds rom_checksum and expected_sum.
`timescale 1ns/1ps
interface rom_load_ctrl_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] rom_wr_addr;
    logic [7:0]  rom_wr_data;
    logic [3:0]  rom_wr_en;
    logic        rom_wr_ack;
    logic        core_reset;
    logic        load_done;
    logic        load_error;
`ifdef CCLIMB_ROM_CHECKSUM_EN
    logic [15:0] rom_checksum;
    logic [15:0] expected_sum;
`endif

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, rom_wr_ack,
`ifdef CCLIMB_ROM_CHECKSUM_EN
        output expected_sum,
        input  rom_checksum,
`endif
        input  ioctl_wait, rom_wr_addr, rom_wr_data, rom_wr_en, core_reset, load_done, load_error
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, rom_wr_ack,
`ifdef CCLIMB_ROM_CHECKSUM_EN
        input  expected_sum,
        output rom_checksum,
`endif
        output ioctl_wait, rom_wr_addr, rom_wr_data, rom_wr_en, core_reset, load_done, load_error
    );
endinterface

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: receives a byte-serial ROM image from the download host,
// splits it into four address regions (CPU, graphics, sound, colour PROM),
// hands each byte to its region with a write/ack handshake, verifies the
// image length and holds the game core in reset until a settle period after
// a good download.
// Build option: CCLIMB_ROM_CHECKSUM_EN adds a 16-bit running sum of accepted
// bytes (rom_checksum) compared with expected_sum at the end of the download.
`timescale 1ns/1ps
module rom_load_ctrl #(
    parameter logic [16:0] ROM_SIZE      = 17'h10000,
    parameter logic [15:0] GFX_BASE      = 16'h6000,
    parameter logic [15:0] SND_BASE      = 16'hA000,
    parameter logic [15:0] PROM_BASE     = 16'hE000,
    parameter logic [7:0]  SETTLE_CYCLES = 8'd255
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    rom_load_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WRITE  = 3'd2,
        SETTLE = 3'd3,
        RUN    = 3'd4
    } state_t;

    state_t      state;
    logic [16:0] byte_cnt;
    logic [7:0]  settle_cnt;
    logic        in_range;
    logic [3:0]  region_hit;
    logic        image_bad;

    // One-hot region select; the bases are ascending so the first match wins.
    function automatic logic [3:0] region_sel(input logic [24:0] addr);
        if (addr < {9'd0, GFX_BASE})
            return 4'b0001;
        else if (addr < {9'd0, SND_BASE})
            return 4'b0010;
        else if (addr < {9'd0, PROM_BASE})
            return 4'b0100;
        else
            return 4'b1000;
    endfunction

    // First address of the region picked by a one-hot select.
    function automatic logic [15:0] region_base(input logic [3:0] sel);
        case (sel)
            4'b0010: return GFX_BASE;
            4'b0100: return SND_BASE;
            4'b1000: return PROM_BASE;
            default: return 16'h0000;
        endcase
    endfunction

    // Byte counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [16:0] sat_inc(input logic [16:0] v);
        return (v == 17'h1FFFF) ? v : v + 17'd1;
    endfunction

    assign in_range   = (bus.ioctl_addr < {8'd0, ROM_SIZE});
    assign region_hit = region_sel(bus.ioctl_addr);

`ifdef CCLIMB_ROM_CHECKSUM_EN
    logic [15:0] sum;
    assign bus.rom_checksum = sum;
    assign image_bad = (byte_cnt != ROM_SIZE) || (sum != bus.expected_sum);
`else
    assign image_bad = (byte_cnt != ROM_SIZE);
`endif

    // Download sequencer: owns every output so they all come straight from flops.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            byte_cnt        <= 17'd0;
            settle_cnt      <= 8'd0;
            bus.ioctl_wait  <= 1'b0;
            bus.rom_wr_addr <= 16'h0000;
            bus.rom_wr_data <= 8'h00;
            bus.rom_wr_en   <= 4'b0000;
            bus.core_reset  <= 1'b1;
            bus.load_done   <= 1'b0;
            bus.load_error  <= 1'b0;
`ifdef CCLIMB_ROM_CHECKSUM_EN
            sum             <= 16'h0000;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.core_reset <= 1'b1;
                    bus.load_done  <= 1'b0;
                    if (bus.ioctl_download) begin
                        state          <= LOAD;
                        byte_cnt       <= 17'd0;
                        bus.load_error <= 1'b0;
`ifdef CCLIMB_ROM_CHECKSUM_EN
                        sum            <= 16'h0000;
`endif
                    end
                end

                LOAD: begin
                    if (!bus.ioctl_download) begin
                        // End of the download window: judge the image, then settle.
                        if (image_bad)
                            bus.load_error <= 1'b1;
                        settle_cnt <= SETTLE_CYCLES;
                        state      <= SETTLE;
                    end else if (bus.ioctl_wr) begin
                        if (in_range) begin
                            bus.rom_wr_addr <= bus.ioctl_addr[15:0] - region_base(region_hit);
                            bus.rom_wr_data <= bus.ioctl_dout;
                            bus.rom_wr_en   <= region_hit;
                            bus.ioctl_wait  <= 1'b1;
                            state           <= WRITE;
                        end else begin
                            bus.load_error <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    // The host must not strobe while we stall it; such bytes are lost.
                    if (bus.ioctl_wr)
                        bus.load_error <= 1'b1;
                    // The pending write always completes, even if the window closed.
                    if (bus.rom_wr_ack) begin
                        bus.rom_wr_en   <= 4'b0000;
                        bus.ioctl_wait  <= 1'b0;
                        bus.rom_wr_addr <= 16'h0000;
                        bus.rom_wr_data <= 8'h00;
                        byte_cnt        <= sat_inc(byte_cnt);
`ifdef CCLIMB_ROM_CHECKSUM_EN
                        sum             <= sum + {8'd0, bus.rom_wr_data};
`endif
                        state           <= LOAD;
                    end
                end

                SETTLE: begin
                    if (bus.ioctl_download) begin
                        state          <= LOAD;
                        bus.core_reset <= 1'b1;
                        byte_cnt       <= 17'd0;
                        bus.load_error <= 1'b0;
`ifdef CCLIMB_ROM_CHECKSUM_EN
                        sum            <= 16'h0000;
`endif
                    end else if (settle_cnt == 8'd0) begin
                        if (bus.load_error) begin
                            state <= IDLE;
                        end else begin
                            state          <= RUN;
                            bus.core_reset <= 1'b0;
                            bus.load_done  <= 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end

                RUN: begin
                    if (bus.ioctl_download) begin
                        state          <= LOAD;
                        bus.core_reset <= 1'b1;
                        bus.load_done  <= 1'b0;
                        byte_cnt       <= 17'd0;
                        bus.load_error <= 1'b0;
`ifdef CCLIMB_ROM_CHECKSUM_EN
                        sum            <= 16'h0000;
`endif
                    end
                end

                default: begin
                    state          <= IDLE;
                    bus.core_reset <= 1'b1;
                    bus.load_done  <= 1'b0;
                    bus.rom_wr_en  <= 4'b0000;
                    bus.ioctl_wait <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb_rom_load_ctrl: randomized downloads against a reference model of the
// region map and the image-validity rules. A second instance with a 4 KiB
// image sees the same host traffic and is used for the complete-download,
// settle-time and RUN checks.
`timescale 1ns/1ps
module tb_rom_load_ctrl;

    localparam int unsigned MAIN_SIZE = 32'h10000;
    localparam int unsigned MAIN_GFX  = 32'h6000;
    localparam int unsigned MAIN_SND  = 32'hA000;
    localparam int unsigned MAIN_PROM = 32'hE000;
    localparam int unsigned FULL_SIZE = 32'h1000;
    localparam int unsigned SETTLE    = 255;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    rom_load_ctrl_if bus ();
    rom_load_ctrl_if bus_full ();

    rom_load_ctrl u_dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    rom_load_ctrl #(
        .ROM_SIZE  (17'h01000),
        .GFX_BASE  (16'h0600),
        .SND_BASE  (16'h0A00),
        .PROM_BASE (16'h0E00)
    ) u_full (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus_full)
    );

    assign bus_full.ioctl_download = bus.ioctl_download;
    assign bus_full.ioctl_wr       = bus.ioctl_wr;
    assign bus_full.ioctl_addr     = bus.ioctl_addr;
    assign bus_full.ioctl_dout     = bus.ioctl_dout;
    assign bus_full.rom_wr_ack     = bus.rom_wr_ack;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ack_delay = 0;
    bit          ack_tied  = 1'b0;
    int          full_wr_cnt = 0;
    logic [27:0] exp_q [$];
    logic [27:0] obs_q [$];
    bit          exp_err;
    int          exp_cnt;
    logic [15:0] exp_sum;

`ifdef CCLIMB_ROM_CHECKSUM_EN
    assign bus.expected_sum      = exp_sum;
    assign bus_full.expected_sum = exp_sum;
`endif

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference region map for the main instance: {one-hot enable, offset, data}.
    function automatic logic [27:0] ref_write(input int unsigned a, input logic [7:0] d);
        int unsigned base [4];
        int          r;
        logic [3:0]  en;
        logic [15:0] off;
        base[0] = 0; base[1] = MAIN_GFX; base[2] = MAIN_SND; base[3] = MAIN_PROM;
        r = 0;
        for (int i = 1; i < 4; i++)
            if (a >= base[i]) r = i;
        en  = 4'(1 << r);
        off = 16'(a - base[r]);
        return {en, off, d};
    endfunction

    task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
        if (int'(a) < int'(MAIN_SIZE)) begin
            exp_q.push_back(ref_write(int'(a), d));
            exp_cnt++;
            exp_sum = exp_sum + {8'd0, d};
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.ioctl_wait && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 100) chk_eq("wait_timeout", 32'(n), 32'd0);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, output int n);
        model_byte(a, d);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        wait_idle(n);
    endtask

    task automatic start_download();
        exp_q.delete();
        obs_q.delete();
        exp_err = 1'b0;
        exp_cnt = 0;
        exp_sum = 16'h0000;
        bus.ioctl_download = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic end_download_and_compare(input string tag);
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk_eq({tag, "_wr_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk_eq({tag, "_wr"}, 32'(obs_q[i]), 32'(exp_q[i]));
        chk_eq({tag, "_err"}, 32'(bus.load_error),
               32'(exp_err || (exp_cnt != int'(MAIN_SIZE))));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_wait"},  32'(bus.ioctl_wait),  32'd0);
        chk_eq({tag, "_addr"},  32'(bus.rom_wr_addr), 32'd0);
        chk_eq({tag, "_data"},  32'(bus.rom_wr_data), 32'd0);
        chk_eq({tag, "_en"},    32'(bus.rom_wr_en),   32'd0);
        chk_eq({tag, "_crst"},  32'(bus.core_reset),  32'd1);
        chk_eq({tag, "_done"},  32'(bus.load_done),   32'd0);
        chk_eq({tag, "_err"},   32'(bus.load_error),  32'd0);
        chk_eq({tag, "_fen"},   32'(bus_full.rom_wr_en),  32'd0);
        chk_eq({tag, "_fcrst"}, 32'(bus_full.core_reset), 32'd1);
    endtask

    // Region side: acknowledges after ack_delay held cycles and checks that a
    // pending write stays frozen with the host stalled while it waits.
    initial begin
        int          hold_cnt;
        logic [27:0] cur_wr;
        hold_cnt = 0;
        cur_wr   = '0;
        bus.rom_wr_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (bus.rom_wr_en != 4'd0) begin
                if (hold_cnt == 0)
                    cur_wr = {bus.rom_wr_en, bus.rom_wr_addr, bus.rom_wr_data};
                else
                    chk_eq("wr_hold", 32'({bus.rom_wr_en, bus.rom_wr_addr, bus.rom_wr_data}),
                           32'(cur_wr));
                chk_eq("wait_hi", 32'(bus.ioctl_wait), 32'd1);
                if (hold_cnt >= ack_delay) begin
                    bus.rom_wr_ack = 1'b1;
                    obs_q.push_back(cur_wr);
                    hold_cnt = 0;
                end else begin
                    bus.rom_wr_ack = 1'b0;
                    hold_cnt++;
                end
            end else begin
                bus.rom_wr_ack = ack_tied;
                hold_cnt = 0;
            end
            if (bus.rom_wr_ack && bus_full.rom_wr_en != 4'd0)
                full_wr_cnt++;
        end
    end

    initial begin
        int n;
        int bad_crst;
        int bad_done;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        exp_err = 1'b0;
        exp_cnt = 0;
        exp_sum = 16'h0000;

        // Power-on reset values
        repeat (3) @(negedge clk_sys);
        chk_reset_outputs("por");
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Short download: fixed region vectors plus random bytes
        start_download();
        chk_eq("dl_start_err",  32'(bus.load_error), 32'd0);
        chk_eq("dl_start_crst", 32'(bus.core_reset), 32'd1);
        ack_delay = 3;
        send_byte(25'h6005, 8'h5A, n);
        chk_eq("ack3_wait_len", 32'(n), 32'(ack_delay + 1));
        ack_delay = 0;
        send_byte(25'hE010, 8'($urandom), n);
        for (int i = 0; i < 98; i++) begin
            ack_delay = $urandom_range(0, 2);
            send_byte(25'($urandom_range(0, 32'hFFFF)), 8'($urandom), n);
        end
        end_download_and_compare("short");
        chk_eq("vec_6005", 32'(obs_q[0]), 32'({4'b0010, 16'h0005, 8'h5A}));
        chk_eq("vec_e010", 32'(obs_q[1][27:8]), 32'({4'b1000, 16'h0010}));
        bad_crst = 0;
        bad_done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sys);
            if (bus.core_reset !== 1'b1) bad_crst++;
            if (bus.load_done !== 1'b0) bad_done++;
        end
        chk_eq("short_crst_held", 32'(bad_crst), 32'd0);
        chk_eq("short_no_done",   32'(bad_done), 32'd0);
        chk_eq("short_err_stick", 32'(bus.load_error), 32'd1);

        // Strobe while a write is stalled: dropped and flagged
        start_download();
        chk_eq("dl2_err_clr", 32'(bus.load_error), 32'd0);
        ack_delay = 3;
        model_byte(25'h0123, 8'hA5);
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0123; bus.ioctl_dout = 8'hA5;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        @(negedge clk_sys);
        exp_err = 1'b1;
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0200; bus.ioctl_dout = 8'h3C;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        wait_idle(n);
        chk_eq("drop_err", 32'(bus.load_error), 32'd1);
        end_download_and_compare("drop");

        // New download while settling restarts loading with a clean error flag
        repeat (5) @(negedge clk_sys);
        start_download();
        chk_eq("resettle_err", 32'(bus.load_error), 32'd0);
        chk_eq("resettle_crst", 32'(bus.core_reset), 32'd1);

        // Out-of-range address: no write, error set
        ack_delay = 0;
        send_byte(25'h10000 | 25'($urandom_range(0, 32'hFFFF)), 8'($urandom), n);
        chk_eq("oor_no_wr", 32'(obs_q.size()), 32'd0);
        chk_eq("oor_err",   32'(bus.load_error), 32'd1);

        // Reset in the middle of a stalled write
        ack_delay = 3;
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0010; bus.ioctl_dout = 8'h77;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        chk_eq("mid_wr_en", 32'(bus.rom_wr_en), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk_sys);
        reset_n = 1'b1;
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk_reset_outputs("postrst");

        // Complete image on the 4 KiB instance with ack tied high
        ack_tied  = 1'b1;
        ack_delay = 0;
        start_download();
        full_wr_cnt = 0;
        for (int i = 0; i < int'(FULL_SIZE); i++)
            send_byte(25'(i), 8'($urandom), n);
        bus.ioctl_download = 1'b0;
        @(posedge clk_sys);
        // count edges after the one that samples ioctl_download low
        n = 0;
        do begin
            @(posedge clk_sys);
            #1;
            n++;
        end while (bus_full.core_reset && n < 400);
        chk_eq("full_settle_len", 32'(n), 32'(SETTLE + 1));
        chk_eq("full_wr_count", 32'(full_wr_cnt), 32'(FULL_SIZE));
        chk_eq("full_done",  32'(bus_full.load_done),  32'd1);
        chk_eq("full_err",   32'(bus_full.load_error), 32'd0);
        chk_eq("full_en",    32'(bus_full.rom_wr_en),  32'd0);
        chk_eq("full_wait",  32'(bus_full.ioctl_wait), 32'd0);
        chk_eq("main_short_err", 32'(bus.load_error), 32'd1);
        chk_eq("main_crst",  32'(bus.core_reset), 32'd1);

        // New download from RUN puts the core back in reset at once
        @(negedge clk_sys);
        bus.ioctl_download = 1'b1;
        @(posedge clk_sys);
        #1;
        chk_eq("run_redl_crst", 32'(bus_full.core_reset), 32'd1);
        chk_eq("run_redl_done", 32'(bus_full.load_done),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/rom_load_ctrl.md
ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 SHALL have parameter ROM_SIZE, default 17'h10000, giving the expected download length in bytes.
REQ-002 SHALL have parameter GFX_BASE, default 16'h6000, giving the first address of region 1 (graphics).
REQ-003 SHALL have parameter SND_BASE, default 16'hA000, giving the first address of region 2 (sound/samples).
REQ-004 SHALL have parameter PROM_BASE, default 16'hE000, giving the first address of region 3 (colour PROMs); region 0 (CPU program) starts at 0.
REQ-005 SHALL have parameter SETTLE_CYCLES, default 8'd255, giving the reset hold after download.
REQ-006 SHALL have ports:
  clk_sys  in  1  system clock; all logic on its rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  ioctl_download  in  1  download window active.
  ioctl_wr  in  1  one-cycle byte strobe.
  ioctl_addr  in  25  byte address.
  ioctl_dout  in  8  byte data.
  ioctl_wait  out  1  back-pressure to the host.
  rom_wr_addr  out  16  region-relative write address.
  rom_wr_data  out  8  write data.
  rom_wr_en  out  4  one-hot region write request.
  rom_wr_ack  in  1  region accepted the write.
  core_reset  out  1  hold the game core in reset.
  load_done  out  1  valid image loaded, core running.
  load_error  out  1  sticky: short, long or overrun download.

Function
REQ-007 SHALL implement the states IDLE, LOAD, WRITE, SETTLE and RUN.
REQ-008 IDLE: core_reset=1; on ioctl_download=1 -> LOAD, clearing the byte counter and load_error.
REQ-009 LOAD: on ioctl_wr with ioctl_addr<ROM_SIZE -> register the address and data, drive rom_wr_en one-hot on the next cycle, assert ioctl_wait, and enter WRITE.
REQ-010 Region decode SHALL be: addr<GFX_BASE -> bit0; addr<SND_BASE -> bit1; addr<PROM_BASE -> bit2; otherwise bit3.
REQ-011 rom_wr_addr SHALL be ioctl_addr[15:0] minus the selected region base, using 16-bit unsigned arithmetic.
REQ-012 WRITE: rom_wr_en, rom_wr_addr and rom_wr_data SHALL be held stable until rom_wr_ack=1 is sampled.
REQ-013 On the cycle rom_wr_ack=1 is sampled, WRITE SHALL drop rom_wr_en and ioctl_wait on the next edge, increment the 17-bit byte counter, and return to LOAD.
REQ-014 ioctl_wr arriving in WRITE SHALL be dropped and SHALL set load_error.
REQ-015 ioctl_wr with ioctl_addr>=ROM_SIZE SHALL perform no write and SHALL set load_error.
REQ-016 ioctl_download falling while in WRITE SHALL complete the pending write before leaving WRITE.
REQ-017 When ioctl_download=0 in LOAD: if the byte counter is not equal to ROM_SIZE, set load_error.
REQ-018 Leaving LOAD per REQ-017: enter SETTLE and load the settle counter with SETTLE_CYCLES.
REQ-019 SETTLE: decrement the counter each cycle; at 0 -> RUN if load_error=0, otherwise -> IDLE.
REQ-020 RUN: core_reset=0 and load_done=1; all other outputs idle.
REQ-021 ioctl_download rising in SETTLE or RUN SHALL return to LOAD on the next edge, with core_reset=1 on that same edge.
REQ-022 core_reset SHALL be 1 in every state except RUN.
REQ-023 rom_wr_en SHALL be nonzero only in WRITE.
REQ-024 The byte counter SHALL saturate at 17'h1FFFF.

Reset
REQ-025 Asserting reset_n=0 at any time, including mid-WRITE, SHALL force IDLE and set all outputs to 0 except core_reset=1.
REQ-026 Reset SHALL clear the byte counter, the settle counter and load_error.

Configuration
REQ-027 With CCLIMB_ROM_CHECKSUM_EN defined, the block SHALL add output rom_checksum (16 bits), the modulo-2^16 sum of the accepted bytes, and input expected_sum (16 bits).
REQ-028 With CCLIMB_ROM_CHECKSUM_EN defined, a mismatch at the end of LOAD SHALL set load_error.
REQ-029 Without CCLIMB_ROM_CHECKSUM_EN, those ports and the checksum logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Full 64 KiB download with rom_wr_ack tied to 1 -> 65536 writes, and core_reset falls 256 cycles after ioctl_download falls.
REQ-031 Byte at ioctl_addr 0x6005 = 0x5A -> rom_wr_en=4'b0010, rom_wr_addr=0x0005, rom_wr_data=0x5A.
REQ-032 Byte at ioctl_addr 0xE010 -> rom_wr_en=4'b1000 and rom_wr_addr=0x0010.
REQ-033 rom_wr_ack delayed 3 cycles -> ioctl_wait high for those cycles, with rom_wr_en, rom_wr_addr and rom_wr_data stable throughout.
REQ-034 Download of 100 bytes, then ioctl_download=0 -> load_error=1, state returns to IDLE, and core_reset stays 1.
REQ-035 reset_n pulsed low during WRITE, then a new download -> all outputs start from reset values.
REQ-036 reset_n pulsed low during WRITE, then a new download -> the byte counter restarts at 0.
